// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB
// buffers and the PC. It handles load-use stalls, taken-branch flushes and
// syscall halt/resume.
// Optional build macro: PIPE_PERF_CNT_EN adds the stall/flush performance counters.
// When the macro is not defined, both counter outputs are tied to zero.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_R1_pos,
  input  logic [4:0]       id_R2_pos,
  input  logic             id_use_R1,
  input  logic             id_use_R2,
  input  logic [4:0]       ex_dst,
  input  logic             ex_is_load,
  input  logic             ex_branch,
  input  logic             ex_halt,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             exmem_en,
  output logic             exmem_clr,
  output logic             memwb_en,
  output logic             memwb_clr,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LSTALL  = 2'b01,
    HALT    = 2'b10,
    RELEASE = 2'b11
  } state_t;

  // The cycle that detects the hazard is the first stall cycle.
  // The counter therefore covers the remaining LOAD_STALL_CYCLES-1 cycles.
  localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

  state_t     cur, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       hz;
  logic       stall_inc;
  logic       flush_inc;

  // Load-use hazard: the ID instruction reads the register that the load in EX writes.
  // Register 0 is hardwired, so a load to it never causes a stall.
  assign hz = ex_is_load && (ex_dst != 5'd0) &&
              ((id_use_R1 && (id_R1_pos == ex_dst)) ||
               (id_use_R2 && (id_R2_pos == ex_dst)));

  // State and stall-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= RUN;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  // Next state and buffer controls.
  // The buffers sample en/clr on the same edge that updates the state.
  always_comb begin
    nxt       = cur;
    cnt_nxt   = cnt;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_en   = 1'b1;
    idex_clr  = 1'b0;
    exmem_en  = 1'b1;
    exmem_clr = 1'b0;
    memwb_en  = 1'b1;
    memwb_clr = 1'b0;
    unique case (cur)
      RUN: begin
        if (ex_halt) begin
          // Freeze every stage so that the syscall stays in EX.
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
          nxt      = HALT;
        end else if (ex_branch) begin
          // Flush the two younger instructions on the wrong path.
          ifid_clr  = 1'b1;
          idex_clr  = 1'b1;
          flush_inc = 1'b1;
        end else if (hz) begin
          // Hold PC and IF/ID, and insert a bubble into EX.
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_clr  = 1'b1;
          stall_inc = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            cnt_nxt = STALL_RELOAD;
            nxt     = LSTALL;
          end
        end
      end
      LSTALL: begin
        // EX holds a bubble here, so branch and halt cannot be real.
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_clr  = 1'b1;
        stall_inc = 1'b1;
        cnt_nxt   = cnt - 4'd1;
        if (cnt == 4'd1) nxt = RUN;
      end
      HALT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        if (resume) nxt = RELEASE;
      end
      RELEASE: begin
        // One free cycle lets the syscall leave EX before ex_halt is looked at again.
        nxt = RUN;
      end
      default: nxt = RUN;
    endcase
    if (rst) begin
      // Empty the whole pipeline while holding the PC.
      pc_en     = 1'b0;
      ifid_en   = 1'b1;
      ifid_clr  = 1'b1;
      idex_en   = 1'b1;
      idex_clr  = 1'b1;
      exmem_en  = 1'b1;
      exmem_clr = 1'b1;
      memwb_en  = 1'b1;
      memwb_clr = 1'b1;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  assign state  = cur;
  assign halted = (cur == HALT);

`ifdef PIPE_PERF_CNT_EN
  // Performance counters. They wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_inc) stall_cycles <= stall_cycles + 1'b1;
      if (flush_inc) flush_count  <= flush_count + 1'b1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf  = stall_inc ^ flush_inc;
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: two DUTs share the same stimulus.
// One uses LOAD_STALL_CYCLES=1 and the other LOAD_STALL_CYCLES=3.
// Each DUT has its own behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  // Control vector order:
  // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr}
  localparam logic [8:0] V_DEF = 9'b110101010;
  localparam logic [8:0] V_FRZ = 9'b000000000;
  localparam logic [8:0] V_STL = 9'b000111010;
  localparam logic [8:0] V_BR  = 9'b111111010;
  localparam logic [8:0] V_RST = 9'b011111111;

  logic clk = 0;
  logic rst;
  logic [4:0] id_R1_pos, id_R2_pos, ex_dst;
  logic id_use_R1, id_use_R2, ex_is_load, ex_branch, ex_halt, resume;

  logic pc_en_1, ifid_en_1, ifid_clr_1, idex_en_1, idex_clr_1, exmem_en_1, exmem_clr_1, memwb_en_1, memwb_clr_1, halted_1;
  logic pc_en_3, ifid_en_3, ifid_clr_3, idex_en_3, idex_clr_3, exmem_en_3, exmem_clr_3, memwb_en_3, memwb_clr_3, halted_3;
  logic [1:0] state_1, state_3;
  logic [CNT_W-1:0] stall_1, flush_1, stall_3, flush_3;
  logic [8:0] ctl_1, ctl_3;

  assign ctl_1 = {pc_en_1, ifid_en_1, ifid_clr_1, idex_en_1, idex_clr_1, exmem_en_1, exmem_clr_1, memwb_en_1, memwb_clr_1};
  assign ctl_3 = {pc_en_3, ifid_en_3, ifid_clr_3, idex_en_3, idex_clr_3, exmem_en_3, exmem_clr_3, memwb_en_3, memwb_clr_3};

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .id_R1_pos(id_R1_pos), .id_R2_pos(id_R2_pos),
    .id_use_R1(id_use_R1), .id_use_R2(id_use_R2), .ex_dst(ex_dst), .ex_is_load(ex_is_load),
    .ex_branch(ex_branch), .ex_halt(ex_halt), .resume(resume),
    .pc_en(pc_en_1), .ifid_en(ifid_en_1), .ifid_clr(ifid_clr_1), .idex_en(idex_en_1),
    .idex_clr(idex_clr_1), .exmem_en(exmem_en_1), .exmem_clr(exmem_clr_1), .memwb_en(memwb_en_1),
    .memwb_clr(memwb_clr_1), .state(state_1), .halted(halted_1), .stall_cycles(stall_1), .flush_count(flush_1));

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(CNT_W)) dut3 (
    .clk(clk), .rst(rst), .id_R1_pos(id_R1_pos), .id_R2_pos(id_R2_pos),
    .id_use_R1(id_use_R1), .id_use_R2(id_use_R2), .ex_dst(ex_dst), .ex_is_load(ex_is_load),
    .ex_branch(ex_branch), .ex_halt(ex_halt), .resume(resume),
    .pc_en(pc_en_3), .ifid_en(ifid_en_3), .ifid_clr(ifid_clr_3), .idex_en(idex_en_3),
    .idex_clr(idex_clr_3), .exmem_en(exmem_en_3), .exmem_clr(exmem_clr_3), .memwb_en(memwb_en_3),
    .memwb_clr(memwb_clr_3), .state(state_3), .halted(halted_3), .stall_cycles(stall_3), .flush_count(flush_3));

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr = 0;
  bit chk_on = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A performance counter value as the DUT should show it in this build.
  function automatic logic [63:0] pcnt(input longint v);
`ifdef PIPE_PERF_CNT_EN
    return 64'(v) & 64'hFFFF_FFFF;
`else
    return 64'(v) * 0;
`endif
  endfunction

  // Behavioural model, one entry per DUT.
  // The model tracks remaining forced stalls, a frozen flag, a release-slot flag and event tallies.
  int     L[2] = '{1, 3};
  int     m_left[2];
  bit     m_frozen[2], m_rel[2];
  longint m_stall[2], m_flush[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_frozen[i] = 0; m_rel[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
  end

  // Compare both DUTs against the model in the middle of every cycle, then advance the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        automatic bit hz = ex_is_load && ex_dst != 0 &&
                           ((id_use_R1 && id_R1_pos == ex_dst) || (id_use_R2 && id_R2_pos == ex_dst));
        automatic logic [8:0] e_ctl;
        automatic logic [1:0] e_st = m_frozen[i] ? 2'd2 : m_rel[i] ? 2'd3 : (m_left[i] > 0) ? 2'd1 : 2'd0;
        if (rst) e_ctl = V_RST;
        else if (m_frozen[i]) e_ctl = V_FRZ;
        else if (m_rel[i]) e_ctl = V_DEF;
        else if (m_left[i] > 0) e_ctl = V_STL;
        else if (ex_halt) e_ctl = V_FRZ;
        else if (ex_branch) e_ctl = V_BR;
        else if (hz) e_ctl = V_STL;
        else e_ctl = V_DEF;
        check(i == 0 ? "ctl_1" : "ctl_3", i == 0 ? ctl_1 : ctl_3, e_ctl);
        check(i == 0 ? "state_1" : "state_3", i == 0 ? state_1 : state_3, e_st);
        check(i == 0 ? "halted_1" : "halted_3", i == 0 ? halted_1 : halted_3, m_frozen[i]);
        check(i == 0 ? "stall_1" : "stall_3", i == 0 ? stall_1 : stall_3, pcnt(m_stall[i]));
        check(i == 0 ? "flush_1" : "flush_3", i == 0 ? flush_1 : flush_3, pcnt(m_flush[i]));
        if (rst) begin
          m_left[i] = 0; m_frozen[i] = 0; m_rel[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end else if (m_frozen[i]) begin
          if (resume) begin m_frozen[i] = 0; m_rel[i] = 1; end
        end else if (m_rel[i]) m_rel[i] = 0;
        else if (m_left[i] > 0) begin m_stall[i]++; m_left[i]--; end
        else if (ex_halt) m_frozen[i] = 1;
        else if (ex_branch) m_flush[i]++;
        else if (hz) begin m_stall[i]++; m_left[i] = L[i] - 1; end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit ld, input int dst, input int r1, input bit u1, input int r2, input bit u2,
                       input bit br, input bit hl, input bit rs);
    ex_is_load = ld; ex_dst = 5'(dst); id_R1_pos = 5'(r1); id_use_R1 = u1;
    id_R2_pos = 5'(r2); id_use_R2 = u2; ex_branch = br; ex_halt = hl; resume = rs;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; idle();
    @(posedge clk); #1 chk_on = 1;
    step();
    check("rst_ctl", ctl_1, V_RST);
    step(); rst = 0; idle(); #1;
    check("post_rst_state", state_3, 2'd0);
    check("post_rst_ctl", ctl_3, V_DEF);
    // T1/T2: load to $8 while ID reads rs=$8.
    step(); drive(1, 8, 8, 1, 0, 0, 0, 0, 0); #1;
    check("t1_ctl_1", ctl_1, V_STL);
    check("t1_state_1", state_1, 2'd0);
    step(); idle(); #1;
    check("t1_after_state_1", state_1, 2'd0);
    check("t1_stall_1", stall_1, pcnt(1));
    check("t1_after_ctl_1", ctl_1, V_DEF);
    check("t2_lstall_state_3", state_3, 2'd1);
    check("t2_lstall_ctl_3", ctl_3, V_STL);
    step(); #1;
    check("t2_lstall2_state_3", state_3, 2'd1);
    step(); #1;
    check("t2_done_state_3", state_3, 2'd0);
    check("t2_done_ctl_3", ctl_3, V_DEF);
    check("t2_stall_3", stall_3, pcnt(3));
    // T3: a branch in the same cycle as a hazard takes priority.
    step(); drive(1, 8, 8, 1, 0, 0, 1, 0, 0); #1;
    check("t3_ctl_1", ctl_1, V_BR);
    step(); idle(); #1;
    check("t3_flush_1", flush_1, pcnt(1));
    check("t3_stall_1", stall_1, pcnt(1));
    // T5: a load to $0 never stalls.
    step(); drive(1, 0, 0, 1, 0, 1, 0, 0, 0); #1;
    check("t5_ctl_1", ctl_1, V_DEF);
    // Hazard through rt only.
    step(); drive(1, 5, 3, 1, 5, 1, 0, 0, 0); #1;
    check("rt_hz_ctl_1", ctl_1, V_STL);
    step(); idle(); step();
    // A matching register is ignored when its use flag is low, and when the EX instruction is not a load.
    step(); drive(1, 5, 5, 0, 5, 0, 0, 0, 0); #1;
    check("no_use_ctl_3", ctl_3, V_DEF);
    step(); drive(0, 5, 5, 1, 5, 1, 0, 0, 0); #1;
    check("no_load_ctl_3", ctl_3, V_DEF);
    // A branch during LSTALL is ignored by the 3-cycle DUT.
    step(); drive(1, 9, 9, 1, 0, 0, 0, 0, 0);
    step(); drive(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
    check("lstall_br_ctl_3", ctl_3, V_STL);
    check("lstall_br_ctl_1", ctl_1, V_BR);
    step(); idle(); step();
    // T4: hold ex_halt, pulse resume, then check the release slot.
    step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    check("t4_freeze_ctl_1", ctl_1, V_FRZ);
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      check("t4_halted_1", halted_1, 1'b1);
      check("t4_ctl_3", ctl_3, V_FRZ);
    end
    step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1); #1;
    check("t4_resume_state_1", state_1, 2'd2);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    check("t4_release_state_1", state_1, 2'd3);
    check("t4_release_ctl_1", ctl_1, V_DEF);
    step(); idle(); #1;
    check("t4_run_state_1", state_1, 2'd0);
    // T6: assert reset during LSTALL while cnt=2.
    step(); drive(1, 7, 0, 0, 7, 1, 0, 0, 0);
    step(); idle(); rst = 1; #1;
    check("t6_mid_state_3", state_3, 2'd1);
    check("t6_rst_ctl_3", ctl_3, V_RST);
    step(); rst = 0; #1;
    check("t6_state_3", state_3, 2'd0);
    check("t6_stall_3", stall_3, 64'd0);
    check("t6_flush_1", flush_1, 64'd0);
    check("t6_ctl_3", ctl_3, V_DEF);
    // Randomised traffic checked by the model.
    for (int k = 0; k < 400; k++) begin
      step();
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end
    step(); rst = 0; idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
